// File: rtl/unidade_muldiv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | muldiv_pkg                                                       |
// | Operation codes, FSM states and iteration count for the unit.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package muldiv_pkg;

    localparam int ITERACOES = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_AJUSTE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/unidade_muldiv_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | unidade_muldiv_if                                                |
// | Issue/result bundle between register file and mul/div unit.      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface unidade_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic             sel_hi;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [4:0]       endRD_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] resultado;
    logic [4:0]       endRD_out;
    logic             erro;

    modport master (
        output start, op, sel_hi, opA, opB, endRD_in,
        input  busy, done, resultado, endRD_out, erro
    );

    modport slave (
        input  start, op, sel_hi, opA, opB, endRD_in,
        output busy, done, resultado, endRD_out, erro
    );
endinterface
`default_nettype wire

// File: rtl/unidade_muldiv_passo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | muldiv_passo                                                     |
// | One combinational shift-add / restoring-divide iteration.        |
// | MULDIV_DIV_EN selects whether the divide step exists.            |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module muldiv_passo #(
    parameter int WIDTH = 32
) (
`ifdef MULDIV_DIV_EN
    input  logic             eh_div,
`endif
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);
    logic [WIDTH:0]   w_soma;
    logic [WIDTH-1:0] w_mult_hi;
    logic [WIDTH-1:0] w_mult_lo;

    // {hi,lo} is the 64-bit accumulator; lo holds the unconsumed multiplier bits.
    assign w_soma    = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    assign w_mult_hi = w_soma[WIDTH:1];
    assign w_mult_lo = {w_soma[0], lo[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]   w_desl;
    logic [WIDTH-1:0] w_dif;
    logic             w_cabe;

    // hi is the partial remainder, lo shifts dividend out and quotient in.
    assign w_desl  = {hi, lo[WIDTH-1]};
    assign w_cabe  = (w_desl >= {1'b0, m});
    assign w_dif   = w_desl[WIDTH-1:0] - m;
    assign hi_next = eh_div ? (w_cabe ? w_dif : w_desl[WIDTH-1:0]) : w_mult_hi;
    assign lo_next = eh_div ? {lo[WIDTH-2:0], w_cabe} : w_mult_lo;
`else
    assign hi_next = w_mult_hi;
    assign lo_next = w_mult_lo;
`endif

endmodule
`default_nettype wire

// File: rtl/unidade_muldiv.sv
`default_nettype none
// +------------------------------------------------------------------+
// | unidade_muldiv                                                   |
// | Iterative 32-bit multiply/divide unit feeding the regfile port.  |
// | Define MULDIV_DIV_EN to include the divider datapath.            |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module unidade_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    unidade_muldiv_if.slave  bus
);
    import muldiv_pkg::*;

    state_t             r_estado;
    logic [5:0]         r_cont;
    logic               r_eh_div;
    logic               r_sel_hi;
    logic [4:0]         r_end;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_m;
    logic               r_neg;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_resultado;
    logic [4:0]         r_end_out;
    logic               r_erro;

    logic               w_com_sinal;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH-1:0]   w_hi_next;
    logic [WIDTH-1:0]   w_lo_next;
    logic [2*WIDTH-1:0] w_prod_mag;
    logic [2*WIDTH-1:0] w_produto;
    logic [WIDTH-1:0]   w_res_mult;

    assign w_com_sinal = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign w_neg_a     = w_com_sinal & bus.opA[WIDTH-1];
    assign w_neg_b     = w_com_sinal & bus.opB[WIDTH-1];
    assign w_mag_a     = w_neg_a ? -bus.opA : bus.opA;
    assign w_mag_b     = w_neg_b ? -bus.opB : bus.opB;

    assign w_prod_mag  = {r_hi, r_lo};
    assign w_produto   = r_neg ? -w_prod_mag : w_prod_mag;
    assign w_res_mult  = r_sel_hi ? w_produto[2*WIDTH-1:WIDTH] : w_produto[WIDTH-1:0];

`ifdef MULDIV_DIV_EN
    logic               r_neg_resto;
    logic               r_div_zero;
    logic [WIDTH-1:0]   w_quoc;
    logic [WIDTH-1:0]   w_resto;
    logic [WIDTH-1:0]   w_res_div;

    // Divide by zero already leaves the dividend in the remainder; only the quotient is forced.
    assign w_quoc    = r_div_zero ? '1 : (r_neg ? -r_lo : r_lo);
    assign w_resto   = r_neg_resto ? -r_hi : r_hi;
    assign w_res_div = r_sel_hi ? w_resto : w_quoc;
`endif

    muldiv_passo #(.WIDTH(WIDTH)) u_passo (
`ifdef MULDIV_DIV_EN
        .eh_div  (r_eh_div),
`endif
        .hi      (r_hi),
        .lo      (r_lo),
        .m       (r_m),
        .hi_next (w_hi_next),
        .lo_next (w_lo_next)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado    <= ST_IDLE;
            r_cont      <= '0;
            r_eh_div    <= 1'b0;
            r_sel_hi    <= 1'b0;
            r_end       <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_m         <= '0;
            r_neg       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_resultado <= '0;
            r_end_out   <= '0;
            r_erro      <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_neg_resto <= 1'b0;
            r_div_zero  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_estado)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_eh_div <= (bus.op == OP_DIV) || (bus.op == OP_DIVU);
                        r_sel_hi <= bus.sel_hi;
                        r_end    <= bus.endRD_in;
                        r_hi     <= '0;
                        r_lo     <= w_mag_a;
                        r_m      <= w_mag_b;
                        r_neg    <= w_neg_a ^ w_neg_b;
                        r_cont   <= '0;
                        r_busy   <= 1'b1;
`ifdef MULDIV_DIV_EN
                        r_neg_resto <= w_neg_a;
                        r_div_zero  <= (bus.opB == '0);
                        r_estado    <= ST_CALC;
`else
                        r_estado <= bus.op[1] ? ST_AJUSTE : ST_CALC;
`endif
                    end
                end
                ST_CALC: begin
                    r_hi   <= w_hi_next;
                    r_lo   <= w_lo_next;
                    r_cont <= r_cont + 6'd1;
                    if (r_cont == 6'(ITERACOES - 1)) begin
                        r_estado <= ST_AJUSTE;
                    end
                end
                ST_AJUSTE: begin
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_end_out <= r_end;
`ifdef MULDIV_DIV_EN
                    r_resultado <= r_eh_div ? w_res_div : w_res_mult;
                    r_erro      <= r_eh_div & r_div_zero;
`else
                    r_resultado <= r_eh_div ? '0 : w_res_mult;
                    r_erro      <= r_eh_div;
`endif
                    r_estado <= ST_IDLE;
                end
                default: r_estado <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.resultado = r_resultado;
    assign bus.endRD_out = r_end_out;
    assign bus.erro      = r_erro;

endmodule
`default_nettype wire

// File: tb/tb_unidade_muldiv.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_unidade_muldiv                                                |
// | Random and directed checks of unidade_muldiv against a model.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_unidade_muldiv;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    always #5 clock = ~clock;

    unidade_muldiv_if #(.WIDTH(32)) bus ();

    unidade_muldiv #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check(input string nome, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at t=%0t", nome, got, exp, $time);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural operands.
    function automatic void calcula(input logic [1:0] op, input logic sel,
                                    input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output logic err,
                                    output int lat);
        longint     sa, sb;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        err = 1'b0;
        lat = 33;
        res = '0;
        if (op[1] == 1'b0) begin
            p   = op[0] ? ({32'b0, a} * {32'b0, b}) : 64'(sa * sb);
            res = sel ? p[63:32] : p[31:0];
        end else begin
`ifdef MULDIV_DIV_EN
            longint q, r;
            if (b == 32'b0) begin
                err = 1'b1;
                res = sel ? a : 32'hFFFF_FFFF;
            end else begin
                if (op[0]) begin
                    q = longint'(a / b);
                    r = longint'(a % b);
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                end
                res = sel ? r[31:0] : q[31:0];
            end
`else
            err = 1'b1;
            res = '0;
            lat = 1;
`endif
        end
    endfunction

    int          m_rem  = 0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_erro = 1'b0;
    logic [31:0] m_res  = '0;
    logic [4:0]  m_end  = '0;
    logic [31:0] p_res;
    logic        p_err;
    logic [4:0]  p_end;

    always @(posedge clock or posedge reset) begin
        int lat;
        if (reset) begin
            m_rem  = 0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_erro = 1'b0;
            m_res  = '0;
            m_end  = '0;
        end else begin
            m_done = 1'b0;
            if (m_rem == 0) begin
                if (bus.start) begin
                    calcula(bus.op, bus.sel_hi, bus.opA, bus.opB, p_res, p_err, lat);
                    p_end  = bus.endRD_in;
                    m_rem  = lat;
                    m_busy = 1'b1;
                end
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    m_done = 1'b1;
                    m_busy = 1'b0;
                    m_res  = p_res;
                    m_erro = p_err;
                    m_end  = p_end;
                end
            end
        end
    end

    always @(negedge clock) begin
        check("busy_done", {62'b0, bus.busy, bus.done}, {62'b0, m_busy, m_done});
        check("resultado", {32'b0, bus.resultado}, {32'b0, m_res});
        check("end_erro",  {58'b0, bus.endRD_out, bus.erro}, {58'b0, m_end, m_erro});
    end

    task automatic drive(input logic [1:0] op, input logic sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        bus.start    = 1'b1;
        bus.op       = op;
        bus.sel_hi   = sel;
        bus.opA      = a;
        bus.opB      = b;
        bus.endRD_in = rd;
    endtask

    // Issues at the current time and waits (bounded) for done.
    task automatic issue_wait(input string nome, input logic [1:0] op, input logic sel,
                              input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                              input logic [31:0] exp_res, input logic exp_err, input int exp_lat);
        int lat;
        lat = -1;
        drive(op, sel, a, b, rd);
        @(posedge clock); #1;
        bus.start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock); #1;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        check({nome, "_lat"}, 64'(lat), 64'(exp_lat));
        check({nome, "_res"}, {32'b0, bus.resultado}, {32'b0, exp_res});
        check({nome, "_erro"}, {63'b0, bus.erro}, {63'b0, exp_err});
        check({nome, "_end"}, {59'b0, bus.endRD_out}, {59'b0, rd});
    endtask

    task automatic run_op(input string nome, input logic [1:0] op, input logic sel,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input logic exp_err, input int exp_lat);
        @(negedge clock); #1;
        issue_wait(nome, op, sel, a, b, rd, exp_res, exp_err, exp_lat);
    endtask

    task automatic run_div(input string nome, input logic [1:0] op, input logic sel,
                           input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                           input logic [31:0] exp_res, input logic exp_err);
        run_op(nome, op, sel, a, b, rd, DIV_ON ? exp_res : 32'h0,
               DIV_ON ? exp_err : 1'b1, DIV_ON ? 33 : 1);
    endtask

    task automatic count_dones(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            if (bus.done) c++;
        end
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        bus.start    = 1'b0;
        bus.op       = 2'b00;
        bus.sel_hi   = 1'b0;
        bus.opA      = '0;
        bus.opB      = '0;
        bus.endRD_in = '0;
        repeat (2) @(negedge clock);
        #1;
        check("reset_state", {25'b0, bus.busy, bus.done, bus.resultado, bus.endRD_out, bus.erro}, 64'h0);
        @(negedge clock); #1;
        reset = 1'b0;

        run_op ("mult_lo",  2'b00, 1'b0, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 1'b0, 33);
        run_op ("mult_hi",  2'b00, 1'b1, 32'd7, 32'hFFFF_FFFD, 5'd2, 32'hFFFF_FFFF, 1'b0, 33);
        run_op ("multu_hi", 2'b01, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 32'hFFFF_FFFE, 1'b0, 33);
        run_op ("multu_lo", 2'b01, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 32'h0000_0001, 1'b0, 33);
        run_div("div_q",    2'b10, 1'b0, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, 1'b0);
        run_div("div_r",    2'b10, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, 1'b0);
        run_div("divu_q",   2'b11, 1'b0, 32'd100, 32'd7, 5'd12, 32'd14, 1'b0);
        run_div("divu_r",   2'b11, 1'b1, 32'd100, 32'd7, 5'd13, 32'd2, 1'b0);
        run_div("dz_q",     2'b11, 1'b0, 32'h1234, 32'd0, 5'd14, 32'hFFFF_FFFF, 1'b1);
        run_div("dz_r",     2'b11, 1'b1, 32'h1234, 32'd0, 5'd15, 32'h0000_1234, 1'b1);
        run_div("ovf_q",    2'b10, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1'b0);
        run_op ("rd0",      2'b01, 1'b0, 32'd6, 32'd7, 5'd0, 32'd42, 1'b0, 33);

        // Start pulsed mid-operation must be dropped.
        @(negedge clock); #1;
        drive(2'b01, 1'b0, 32'd3, 32'd5, 5'd3);
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        drive(2'b00, 1'b0, 32'd9, 32'd9, 5'd4);
        @(posedge clock); #1;
        bus.start = 1'b0;
        count_dones(22, n);
        check("busy_ign_done", {63'b0, bus.done}, 64'h1);
        check("busy_ign_res", {32'b0, bus.resultado}, 64'd15);
        count_dones(40, n);
        check("busy_ign_extra", 64'(n), 64'h0);

        // Back-to-back: start issued during the done cycle.
        run_op    ("b2b_a", 2'b00, 1'b0, 32'hFFFF_FFFF, 32'd2, 5'd20, 32'hFFFF_FFFE, 1'b0, 33);
        issue_wait("b2b_b", 2'b01, 1'b1, 32'h8000_0000, 32'd4, 5'd21, 32'h0000_0002, 1'b0, 33);

        // Reset in the middle of CALC.
        @(negedge clock); #1;
        drive(2'b01, 1'b0, 32'd11, 32'd13, 5'd22);
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (15) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("rst_mid", {25'b0, bus.busy, bus.done, bus.resultado, bus.endRD_out, bus.erro}, 64'h0);
        @(negedge clock); #1;
        reset = 1'b0;
        count_dones(40, n);
        check("rst_no_done", 64'(n), 64'h0);
        run_op("after_rst", 2'b00, 1'b0, 32'hFFFF_FFF6, 32'hFFFF_FFF6, 5'd23, 32'd100, 1'b0, 33);

        // Random traffic; the per-cycle compare process does the checking.
        for (int c = 0; c < 2500; c++) begin
            @(negedge clock); #1;
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 399) == 0) reset = 1'b1;
            bus.start    = ($urandom_range(0, 3) == 0);
            bus.op       = 2'($urandom_range(0, 3));
            bus.sel_hi   = 1'($urandom_range(0, 1));
            bus.opA      = rnd_operand();
            bus.opB      = rnd_operand();
            bus.endRD_in = 5'($urandom_range(0, 31));
        end
        @(negedge clock); #1;
        bus.start = 1'b0;
        reset     = 1'b0;
        repeat (40) @(posedge clock);
        @(negedge clock); #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
